// File: rtl/seq_gen_if.sv
// Handshake bundle for seq_gen: request/cancel inputs and the registered
// serial symbol stream with its status flags.
interface seq_gen_if;
  logic       start;
  logic [3:0] count;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, count, abort,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, count, abort,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq_gen.sv
// Repeating serial pattern generator: emits `count` frames of PATTERN
// (MSB first), GAP idle cycles apart, followed by a one-cycle done pulse.
module seq_gen #(
  parameter int                 PAT_LEN  = 5,
  parameter logic [PAT_LEN-1:0] PATTERN  = 5'b00111,
  parameter int                 GAP      = 2,
  parameter logic               IDLE_LVL = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  seq_gen_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_SEND = 4'b0010,
    S_GAP  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  // Pattern left-justified in a byte so symbol k is always PAT8[7-k].
  localparam logic [7:0] PAT8     = 8'(PATTERN) << (8 - PAT_LEN);
  localparam logic [2:0] LAST_IDX = 3'(PAT_LEN - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  state_t     state;
  logic [3:0] rep_cnt;
  logic [2:0] bit_idx;
  logic [3:0] gap_cnt;
  logic       dout_q;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;

  function automatic logic sym(input logic [2:0] idx);
    return PAT8[3'd7 - idx];
  endfunction

  // Outputs are registered for the state being entered, so bit_idx names the
  // symbol currently on dout rather than the next one.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // a blocking = would let later statements read the new value this cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: control state is reset explicitly; only a synchronous reset is
      // used, so no asynchronous path exists into these flops.
      state   <= S_IDLE;
      rep_cnt <= 4'd0;
      bit_idx <= 3'd0;
      gap_cnt <= 4'd0;
      dout_q  <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.abort) begin
      state   <= S_IDLE;
      rep_cnt <= 4'd0;
      bit_idx <= 3'd0;
      gap_cnt <= 4'd0;
      dout_q  <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start && bus.count != 4'd0) begin
            state   <= S_SEND;
            rep_cnt <= bus.count;
            bit_idx <= 3'd0;
            dout_q  <= sym(3'd0);
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        S_SEND: begin
          if (bit_idx == LAST_IDX) begin
            rep_cnt <= rep_cnt - 4'd1;
            bit_idx <= 3'd0;
            if (rep_cnt == 4'd1) begin
              state   <= S_DONE;
              dout_q  <= IDLE_LVL;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (GAP == 0) begin
              dout_q  <= sym(3'd0);
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_LAST;
              dout_q  <= IDLE_LVL;
              valid_q <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + 3'd1;
            dout_q  <= sym(bit_idx + 3'd1);
          end
        end

        S_GAP: begin
          if (gap_cnt == 4'd0) begin
            state   <= S_SEND;
            bit_idx <= 3'd0;
            dout_q  <= sym(3'd0);
            valid_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          rep_cnt <= 4'd0;
          bit_idx <= 3'd0;
          gap_cnt <= 4'd0;
          dout_q  <= IDLE_LVL;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  a_onehot:     assert property (@(posedge clk) disable iff (!rst) $onehot(state));
  a_valid_busy: assert property (@(posedge clk) disable iff (!rst) valid_q |-> busy_q);
  a_done_busy:  assert property (@(posedge clk) disable iff (!rst) done_q |-> busy_q);

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter PAT_LEN, default 5: number of symbols per pattern frame, range 1..8.
REQ-002 Parameter PATTERN, default 5'b00111: frame symbols, sent MSB first (B=0, C=1), giving B,B,C,C,C.
REQ-003 Parameter GAP, default 2: idle cycles between repeated frames, range 0..15.
REQ-004 Parameter IDLE_LVL, default 1'b1: dout level whenever no symbol is being sent (C level).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low.
REQ-007 start  input  1  request pulse; sampled only in S_IDLE.
REQ-008 count  input  4  frames to send; latched with an accepted start.
REQ-009 abort  input  1  synchronous cancel; takes priority over all other inputs except rst.
REQ-010 dout  output  1  serial symbol stream, registered.
REQ-011 dout_valid  output  1  high exactly on cycles carrying a pattern symbol.
REQ-012 busy  output  1  high from the cycle after an accepted start through the done cycle inclusive.
REQ-013 done  output  1  one-cycle pulse after the last symbol of the last frame.

Function
REQ-014 The FSM SHALL be one-hot with states S_IDLE, S_SEND, S_GAP and S_DONE.
REQ-015 S_IDLE: start=1 and count!=0 SHALL latch count into rep_cnt, clear bit_idx, and move to S_SEND; start with count=0 SHALL be ignored (no busy, no done).
REQ-016 Latency: if start is accepted at edge N, the first symbol SHALL appear on dout with dout_valid=1 in the cycle after edge N.
REQ-017 S_SEND SHALL output PATTERN[PAT_LEN-1-bit_idx], one symbol per cycle, and increment bit_idx (width 3 bits, wraps to 0 at PAT_LEN-1).
REQ-018 At the end of a frame, rep_cnt SHALL decrement; if rep_cnt becomes 0, next state is S_DONE; otherwise next state is S_GAP, or directly the first symbol of the next frame in S_SEND when GAP=0 (back-to-back, no idle cycle).
REQ-019 S_GAP SHALL hold dout=IDLE_LVL and dout_valid=0 for exactly GAP cycles using a 4-bit gap counter, then return to S_SEND with bit_idx=0.
REQ-020 S_DONE SHALL assert done=1 and busy=1 for one cycle with dout=IDLE_LVL and dout_valid=0, then return to S_IDLE.
REQ-021 start asserted in any state other than S_IDLE SHALL be ignored and SHALL NOT reload count.
REQ-022 abort=1 in any state SHALL force S_IDLE at the next edge, with dout=IDLE_LVL, dout_valid=0 and busy=0 from that edge; done SHALL NOT pulse; a simultaneous start SHALL be ignored.
REQ-023 In S_IDLE, dout SHALL equal IDLE_LVL and dout_valid, busy and done SHALL be 0.
REQ-024 Total busy duration for count=K SHALL be K*PAT_LEN + (K-1)*GAP + 1 cycles.
REQ-025 A new start SHALL be accepted in the cycle immediately after done (first S_IDLE cycle).

Reset
REQ-026 rst=0 at a rising edge SHALL force S_IDLE, rep_cnt=0, bit_idx=0, gap counter=0, dout=IDLE_LVL, dout_valid=0, busy=0, done=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without a done pulse; reset SHALL override start and abort.

Verification
REQ-028 Defaults, start=1 with count=1 at edge N -> dout=0,0,1,1,1 with dout_valid=1 for cycles N+1..N+5; done=1 at N+6; busy high N+1..N+6.
REQ-029 count=3, GAP=2 -> three BBCCC frames separated by 2 cycles at dout=1 with dout_valid=0; busy=20 cycles; exactly one done pulse.
REQ-030 GAP=0, count=2 -> 10 consecutive valid symbols 0011100111; done in the 11th cycle.
REQ-031 start with count=0 -> no state change; busy, dout_valid and done remain 0; dout remains 1.
REQ-032 abort on the 3rd symbol of a count=2 run -> next cycle S_IDLE, dout=1, busy=0, no done; a subsequent start with count=1 produces a clean 00111.
REQ-033 rst=0 during S_GAP, plus start pulses while busy -> all outputs return to reset values; pulses while busy do not extend or restart the run; loopback into the BBCCC detector yields one detection per frame.
